// File: rtl/gray_stream_decoder.sv
// Gray-coded stream decoder.
// Decodes each accepted gray sample to binary and checks that it is
// gray-adjacent to the previously accepted sample. Reports the step
// direction, repeated samples and adjacency errors, and keeps a saturating
// count of adjacency errors.
module gray_stream_decoder #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 clear_err,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 dir_up,
  output logic                 hold,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  // EMPTY: no reference sample yet; TRACK: prev_gray/prev_bin hold a reference.
  typedef enum logic {
    EMPTY = 1'b0,
    TRACK = 1'b1
  } state_t;

  state_t               state, state_n;
  logic [WIDTH-1:0]     prev_gray, prev_gray_n;
  logic [WIDTH-1:0]     prev_bin, prev_bin_n;
  logic [WIDTH-1:0]     bin_n;
  logic                 out_valid_n, dir_up_n, hold_n, step_err_n;
  logic [ERR_CNT_W-1:0] err_count_n;

  logic [WIDTH-1:0]     dec_bin;
  logic [WIDTH-1:0]     diff;
  logic                 same, single;

  // Gray-to-binary decode: prefix XOR from the MSB down.
  always_comb begin
    dec_bin            = '0;
    dec_bin[WIDTH-1]   = gray_in[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      dec_bin[i] = dec_bin[i+1] ^ gray_in[i];
    end
  end

  // Bit distance to the previous sample: zero bits or exactly one bit (power of two).
  always_comb begin
    diff   = gray_in ^ prev_gray;
    same   = (diff == '0);
    single = !same && ((diff & (diff - WIDTH'(1))) == '0);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state;
    prev_gray_n = prev_gray;
    prev_bin_n  = prev_bin;
    bin_n       = bin_out;
    dir_up_n    = dir_up;
    out_valid_n = 1'b0;
    hold_n      = 1'b0;
    step_err_n  = 1'b0;
    err_count_n = err_count;

    if (in_valid) begin
      out_valid_n = 1'b1;
      bin_n       = dec_bin;
      prev_gray_n = gray_in;
      prev_bin_n  = dec_bin;
      case (state)
        EMPTY: begin
          state_n = TRACK;
        end
        TRACK: begin
          if (same) begin
            hold_n = 1'b1;
          end else if (single) begin
            dir_up_n = (dec_bin == (prev_bin + WIDTH'(1)));
          end else begin
            step_err_n = 1'b1;
            if (err_count != ERR_MAX) begin
              err_count_n = err_count + ERR_CNT_W'(1);
            end
          end
        end
        default: state_n = EMPTY;
      endcase
    end

    // Clear wins over a same-cycle increment.
    if (clear_err) begin
      err_count_n = '0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      prev_gray <= '0;
      prev_bin  <= '0;
      out_valid <= 1'b0;
      bin_out   <= '0;
      dir_up    <= 1'b0;
      hold      <= 1'b0;
      step_err  <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      prev_gray <= prev_gray_n;
      prev_bin  <= prev_bin_n;
      out_valid <= out_valid_n;
      bin_out   <= bin_n;
      dir_up    <= dir_up_n;
      hold      <= hold_n;
      step_err  <= step_err_n;
      err_count <= err_count_n;
    end
  end

endmodule

// File: tb/tb_gray_stream_decoder.sv
// Scoreboard bench for gray_stream_decoder: directed sequences followed by
// random traffic, checked against a table-driven reference model.
module tb_gray_stream_decoder;

  localparam int unsigned W  = 4;
  localparam int unsigned EW = 2;
  localparam int          NV = 1 << W;
  localparam int          EMAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst, in_valid, clear_err;
  logic [W-1:0]  gray_in;
  logic          out_valid, dir_up, hold, step_err;
  logic [W-1:0]  bin_out;
  logic [EW-1:0] err_count;

  gray_stream_decoder #(.WIDTH(W), .ERR_CNT_W(EW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .gray_in(gray_in),
    .clear_err(clear_err), .out_valid(out_valid), .bin_out(bin_out),
    .dir_up(dir_up), .hold(hold), .step_err(step_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  bin;
    logic          dir;
    logic          hld;
    logic          serr;
    logic [EW-1:0] err;
  } exp_t;

  exp_t q[$];

  // Reference model state
  logic [W-1:0]  tbl [NV];
  logic          m_empty = 1'b1;
  logic [W-1:0]  m_prev_gray = '0;
  int            m_prev_val = 0;
  logic [W-1:0]  m_bin = '0;
  logic          m_dir = 1'b0;
  int            m_err = 0;

  int passed = 0;
  int total  = 0;
  logic done = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model of one clock edge.
  task automatic model(input logic r, input logic v, input logic [W-1:0] g, input logic c);
    exp_t e;
    int   nv, d;
    logic h, s;
    if (r) begin
      m_empty = 1'b1; m_prev_gray = '0; m_prev_val = 0;
      m_bin = '0; m_dir = 1'b0; m_err = 0;
      q.delete();
      return;
    end
    if (v) begin
      nv = int'(tbl[g]);
      h = 1'b0; s = 1'b0;
      if (!m_empty) begin
        d = $countones(g ^ m_prev_gray);
        if (d == 0) h = 1'b1;
        else if (d == 1) m_dir = (nv == ((m_prev_val + 1) % NV));
        else begin
          s = 1'b1;
          if (m_err < EMAX) m_err++;
        end
      end
      if (c) m_err = 0;
      m_bin = W'(nv);
      e.bin = W'(nv); e.dir = m_dir; e.hld = h; e.serr = s; e.err = EW'(m_err);
      q.push_back(e);
      m_prev_gray = g; m_prev_val = nv; m_empty = 1'b0;
    end else if (c) begin
      m_err = 0;
    end
  endtask

  // Drive one cycle of inputs and advance the model at the edge.
  task automatic cyc(input logic r, input logic v, input logic [W-1:0] g, input logic c);
    @(negedge clk);
    rst = r; in_valid = v; gray_in = g; clear_err = c;
    @(posedge clk);
    model(r, v, g, c);
  endtask

  task automatic send(input logic [W-1:0] g);
    cyc(1'b0, 1'b1, g, 1'b0);
  endtask

  // Monitor: compare every presented output with the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      if (out_valid === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("bin_out", int'(bin_out), int'(e.bin));
          chk("dir_up", int'(dir_up), int'(e.dir));
          chk("hold", int'(hold), int'(e.hld));
          chk("step_err", int'(step_err), int'(e.serr));
          chk("err_count", int'(err_count), int'(e.err));
        end
      end else begin
        chk("out_valid_low", int'(out_valid), 0);
        chk("idle_hold", int'(hold), 0);
        chk("idle_step_err", int'(step_err), 0);
        chk("idle_bin_out", int'(bin_out), int'(m_bin));
        chk("idle_dir_up", int'(dir_up), int'(m_dir));
        chk("idle_err_count", int'(err_count), m_err);
      end
    end
  end

  initial begin
    logic [W-1:0] seq1 [16];
    logic [W-1:0] lastg;
    logic [W-1:0] g;
    logic         v;

    for (int i = 0; i < NV; i++) tbl[W'(i ^ (i >> 1))] = W'(i);
    seq1 = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
             4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

    rst = 1'b1; in_valid = 1'b0; gray_in = '0; clear_err = 1'b0;
    cyc(1'b1, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0);

    // Full gray count 0..15
    for (int i = 0; i < 16; i++) send(seq1[i]);
    // Wrap and reverse
    send(4'b1001); send(4'b1000); send(4'b0000); send(4'b0000); send(4'b1000);
    // Jump
    send(4'b0001); send(4'b0110);
    // Gap handling
    send(4'b0011);
    repeat (3) cyc(1'b0, 1'b0, 4'b1111, 1'b0);
    send(4'b0010);
    // Saturation, then clear with a simultaneous error
    for (int i = 0; i < 6; i++) send((i % 2 == 0) ? 4'b0000 : 4'b0011);
    cyc(1'b0, 1'b1, 4'b0000, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0);
    // Reset mid-stream; next sample unchecked
    send(4'b0101);
    cyc(1'b1, 1'b0, '0, 1'b0);
    send(4'b1010);
    cyc(1'b0, 1'b0, '0, 1'b0);

    // Random traffic, mostly adjacent steps
    lastg = 4'b1010;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 5))
        0:       g = W'($urandom_range(0, NV - 1));
        1:       g = lastg;
        default: g = lastg ^ W'(1 << $urandom_range(0, W - 1));
      endcase
      v = ($urandom_range(0, 3) != 0);
      cyc(($urandom_range(0, 99) == 0), v, g, ($urandom_range(0, 19) == 0));
      if (v) lastg = g;
    end

    cyc(1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    done = 1'b1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
